key_push_gen: RTL and testbench

//  Conditions a raw DE2 push-button into the push request that the tik-clocked LED pattern

---
 rtl/key_push_gen.sv | 109 ++++++++++
 tb/tb_key_push_gen.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/key_push_gen.sv
// Push-button conditioner: 2-FF sync, debounce, press detect, and a push request held
// until the slow consumer's tik strobe has seen it.
module key_push_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_raw,
  input  logic       tik,
  output logic       key_level,
  output logic       press,
  output logic       push,
  output logic       push_lost,
  output logic [1:0] press_cnt
);

  localparam logic             RELEASED = ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, PENDING} state_t;

  logic             sync1_q, sync2_q;
  logic             key_sync;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  state_t           state_q, state_d;
  logic [1:0]       press_cnt_q, press_cnt_d;
  logic             lost_q, lost_d;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q <= RELEASED;
      sync2_q <= RELEASED;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  // Normalised so that 1 always means "pressed", whatever the board polarity.
  assign key_sync = sync2_q ^ RELEASED;

  always_comb begin
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    press_d  = 1'b0;
    if (key_sync == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == CNT_LAST) begin
      level_d  = key_sync;
      db_cnt_d = '0;
      press_d  = key_sync;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    press_cnt_d = press_cnt_q;
    lost_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_q) begin
          state_d     = PENDING;
          press_cnt_d = press_cnt_q + 2'd1;
        end
      end
      PENDING: begin
        if (press_q) begin
          // A press landing on the tik is a fresh request; otherwise the old one absorbs it.
          if (tik) press_cnt_d = press_cnt_q + 2'd1;
          else     lost_d      = 1'b1;
        end else if (tik) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      db_cnt_q    <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      state_q     <= IDLE;
      press_cnt_q <= 2'd0;
      lost_q      <= 1'b0;
    end else begin
      db_cnt_q    <= db_cnt_d;
      level_q     <= level_d;
      press_q     <= press_d;
      state_q     <= state_d;
      press_cnt_q <= press_cnt_d;
      lost_q      <= lost_d;
    end
  end

  assign key_level = level_q;
  assign press     = press_q;
  assign push      = (state_q == PENDING);
  assign push_lost = lost_q;
  assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_key_push_gen.sv
// Self-checking bench for key_push_gen: directed scenarios plus randomized key/tik
// traffic, compared every cycle against a rule-level reference model.
module tb_key_push_gen;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset, key_raw, tik;
  logic       key_level, press, push, push_lost;
  logic [1:0] press_cnt;

  int n_checks = 0;
  int n_errors = 0;

  key_push_gen #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .ACTIVE_LOW(1'b1)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .key_raw  (key_raw),
    .tik      (tik),
    .key_level(key_level),
    .press    (press),
    .push     (push),
    .push_lost(push_lost),
    .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit m_lvl, m_press, m_pend, m_lost;
  int m_cnt, m_run;
  bit dl[$];

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the specified behaviour, using the inputs present before the edge.
  task automatic model_step(input bit raw, input bit t, input bit r);
    bit s, pressed, new_lost, new_press;
    if (r) begin
      dl = '{1'b1, 1'b1};
      m_lvl = 0; m_press = 0; m_pend = 0; m_lost = 0; m_cnt = 0; m_run = 0;
      return;
    end
    s = dl.pop_front();
    dl.push_back(raw);
    pressed = ~s;
    new_lost = m_pend && m_press && !t;
    if (m_press && (!m_pend || t)) m_cnt = (m_cnt + 1) % 4;
    if (m_press) m_pend = 1;
    else if (t)  m_pend = 0;
    m_lost = new_lost;
    new_press = 0;
    if (pressed != m_lvl) begin
      m_run++;
      if (m_run == D) begin
        m_lvl = pressed;
        m_run = 0;
        new_press = pressed;
      end
    end else begin
      m_run = 0;
    end
    m_press = new_press;
  endtask

  task automatic step(input bit raw, input bit t, input bit r);
    key_raw = raw;
    tik     = t;
    reset   = r;
    @(posedge clk);
    model_step(raw, t, r);
    #1;
    check_eq("key_level", 8'(key_level), 8'(m_lvl));
    check_eq("press",     8'(press),     8'(m_press));
    check_eq("push",      8'(push),      8'(m_pend));
    check_eq("push_lost", 8'(push_lost), 8'(m_lost));
    check_eq("press_cnt", 8'(press_cnt), 8'(m_cnt));
  endtask

  // mode 0: no tik, 1: tik on every cycle the model expects press, 2: random tik
  task automatic hold(input bit raw, input int n, input int mode);
    bit t;
    for (int i = 0; i < n; i++) begin
      t = (mode == 1) ? m_press : (mode == 2) ? ($urandom_range(5) == 0) : 1'b0;
      step(raw, t, 1'b0);
    end
  endtask

  task automatic press_txn(input string name, input int n, input int mode);
    hold(1'b0, n, mode);
    hold(1'b1, n, mode);
    $display("txn %s: level=%0d push=%0d lost=%0d cnt=%0d", name, key_level, push, push_lost, press_cnt);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    bit raw;
    int len;
    key_raw = 1'b1; tik = 1'b0; reset = 1'b1;

    // 1. reset and idle released key
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check_eq("rst_push", 8'(push), 8'd0);
    check_eq("rst_cnt", 8'(press_cnt), 8'd0);
    hold(1'b1, 50, 0);
    $display("txn idle: level=%0d push=%0d cnt=%0d", key_level, push, press_cnt);

    // 2. clean press, measure edge-to-level latency
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0, 1'b0);
      if (key_level && first < 0) first = k;
    end
    check_eq("latency", 8'(first), 8'(D + 2));
    hold(1'b1, 20, 0);
    check_eq("press1_push", 8'(push), 8'd1);
    check_eq("press1_cnt", 8'(press_cnt), 8'd1);
    $display("txn press: latency=%0d push=%0d cnt=%0d", first, push, press_cnt);

    // 3. glitch shorter than the debounce window
    hold(1'b0, 3, 0);
    hold(1'b1, 10, 0);
    check_eq("glitch_level", 8'(key_level), 8'd0);
    $display("txn glitch: level=%0d push=%0d", key_level, push);

    // 4. tik consumes the pending push
    check_eq("pre_tik_push", 8'(push), 8'd1);
    step(1'b1, 1'b1, 1'b0);
    check_eq("post_tik_push", 8'(push), 8'd0);
    $display("txn tik: push=%0d", push);

    // 5. two presses with no tik, then one coincident with tik
    press_txn("press_a", 20, 0);
    press_txn("press_lost", 20, 0);
    check_eq("lost_cnt", 8'(press_cnt), 8'd2);
    press_txn("press_on_tik", 20, 1);
    check_eq("tik_press_cnt", 8'(press_cnt), 8'd3);
    check_eq("tik_press_push", 8'(push), 8'd1);

    // 6. four consumed presses wrap the counter, then reset while pending
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      press_txn("press_wrap", 20, 0);
      step(1'b1, 1'b1, 1'b0);
    end
    check_eq("wrap_cnt", 8'(press_cnt), 8'd3);
    press_txn("press_pre_reset", 20, 0);
    step(1'b1, 1'b0, 1'b1);
    check_eq("reset_push", 8'(push), 8'd0);
    check_eq("reset_cnt", 8'(press_cnt), 8'd0);
    $display("txn reset: push=%0d cnt=%0d", push, press_cnt);

    // Random traffic: glitches, real presses, random tiks and occasional resets
    raw = 1'b1;
    for (int seg = 0; seg < 300; seg++) begin
      raw = ~raw;
      len = $urandom_range(1, 14);
      hold(raw, len, 2);
      if ($urandom_range(59) == 0) step(1'b1, 1'b0, 1'b1);
      $display("txn rand %0d: raw=%0d len=%0d level=%0d push=%0d cnt=%0d",
               seg, raw, len, key_level, push, press_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
